// File: rtl/ee354_detour_pkg.sv
// Shared constants for the detour-sign direction front-end.
// The one-hot debounce states and the default timing constants live here.
package ee354_detour_pkg;

  typedef logic [3:0] db_state_t;

  localparam db_state_t DB_IDLE    = 4'b0001;
  localparam db_state_t DB_WAITP   = 4'b0010;
  localparam db_state_t DB_PRESSED = 4'b0100;
  localparam db_state_t DB_WAITR   = 4'b1000;
  localparam int        DB_PRESSED_BIT = 2;

  localparam int DB_COUNT_DEF    = 1_000_000;
  localparam int TICK_PERIOD_DEF = 50_000_000;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ee354_debounce.sv
// One push-button: 2-flop synchroniser, one-hot debounce FSM and a
// single-cycle pulse per accepted press.
module ee354_debounce
  import ee354_detour_pkg::*;
#(
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int            CW       = cnt_w(DB_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic          btn_p0;
  logic          btn_p1;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Synchroniser stage boundary
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
    end
  end

  // Counter is cleared on every state change, so it never wraps.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DB_IDLE: begin
          cnt <= '0;
          if (btn_p1) state <= DB_WAITP;
        end
        DB_WAITP: begin
          if (!btn_p1) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          state <= DB_WAITR;
          cnt   <= '0;
        end
        DB_WAITR: begin
          if (btn_p1) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pulse = state[DB_PRESSED_BIT];

endmodule

// File: rtl/ee354_detour_dir_ctrl.sv
// Detour-sign front-end: debounced L/R buttons, pending direction, step tick.
// Define DETOUR_HOLD_EN to add the Hold input that freezes the step tick.
module ee354_detour_dir_ctrl
  import ee354_detour_pkg::*;
#(
  parameter int DB_COUNT    = DB_COUNT_DEF,
  parameter int TICK_PERIOD = TICK_PERIOD_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic BtnL,
  input  logic BtnR,
`ifdef DETOUR_HOLD_EN
  input  logic Hold,
`endif
  output logic L_Rbar,
  output logic Sm_Tick,
  output logic BtnL_Pulse,
  output logic BtnR_Pulse
);

  localparam int            TW        = cnt_w(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);

  logic [TW-1:0] tick_cnt;
  logic          pend_dir;
  logic          run;

`ifdef DETOUR_HOLD_EN
  assign run = ~Hold;
`else
  assign run = 1'b1;
`endif

  ee354_debounce #(.DB_COUNT(DB_COUNT)) u_db_l (
    .Clk   (Clk),
    .reset (reset),
    .btn   (BtnL),
    .pulse (BtnL_Pulse)
  );

  ee354_debounce #(.DB_COUNT(DB_COUNT)) u_db_r (
    .Clk   (Clk),
    .reset (reset),
    .btn   (BtnR),
    .pulse (BtnR_Pulse)
  );

  // Tick stage boundary: a frozen counter keeps its value and suppresses the tick
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      Sm_Tick  <= 1'b0;
    end else if (!run) begin
      Sm_Tick <= 1'b0;
    end else begin
      Sm_Tick  <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // Direction stage boundary: a pulse coinciding with Sm_Tick lands in pend_dir
  // on the same edge that L_Rbar samples the old value, so it waits one period.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pend_dir <= 1'b0;
      L_Rbar   <= 1'b0;
    end else begin
      if (BtnL_Pulse && !BtnR_Pulse)      pend_dir <= 1'b1;
      else if (BtnR_Pulse && !BtnL_Pulse) pend_dir <= 1'b0;
      if (Sm_Tick) L_Rbar <= pend_dir;
    end
  end

endmodule

// File: tb/tb_ee354_detour_dir_ctrl.sv
// Scoreboard bench for ee354_detour_dir_ctrl (DB_COUNT=4, TICK_PERIOD=8).
// Expected output events are queued by the driver; a monitor pops them as they appear.
module tb_ee354_detour_dir_ctrl;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic BtnL = 1'b0;
  logic BtnR = 1'b0;
  logic Hold = 1'b0;
  logic L_Rbar, Sm_Tick, BtnL_Pulse, BtnR_Pulse;

  int total = 0;
  int bad = 0;
  int cyc;

  typedef struct {
    int   cyc;
    logic tick;
    logic lp;
    logic rp;
    logic lr;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;

  always #5 Clk = ~Clk;

  ee354_detour_dir_ctrl #(.DB_COUNT(4), .TICK_PERIOD(8)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
`ifdef DETOUR_HOLD_EN
    .Hold       (Hold),
`endif
    .L_Rbar     (L_Rbar),
    .Sm_Tick    (Sm_Tick),
    .BtnL_Pulse (BtnL_Pulse),
    .BtnR_Pulse (BtnR_Pulse)
  );

  // cyc = number of rising edges since reset was released
  always @(posedge Clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic t, input logic lp, input logic rp, input logic lr);
    ev_t e;
    e.cyc = c; e.tick = t; e.lp = lp; e.rp = rp; e.lr = lr;
    sb.push_back(e);
  endtask

  task automatic wu(input int n);
    while (cyc < n) @(negedge Clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_L_Rbar"}, {31'b0, L_Rbar}, 0);
    chk({tag, "_Sm_Tick"}, {31'b0, Sm_Tick}, 0);
    chk({tag, "_BtnL_Pulse"}, {31'b0, BtnL_Pulse}, 0);
    chk({tag, "_BtnR_Pulse"}, {31'b0, BtnR_Pulse}, 0);
  endtask

  // Monitor
  always @(negedge Clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL missing_event: expected at cycle %0d (tick=%0b lp=%0b rp=%0b), got nothing by cycle %0d",
                 mon_e.cyc, mon_e.tick, mon_e.lp, mon_e.rp, cyc);
      end
      if (Sm_Tick || BtnL_Pulse || BtnR_Pulse) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event at cycle %0d: tick=%0b lp=%0b rp=%0b, expected none",
                   cyc, Sm_Tick, BtnL_Pulse, BtnR_Pulse);
        end else begin
          mon_e = sb.pop_front();
          chk("ev_cycle", cyc, mon_e.cyc);
          chk("ev_Sm_Tick", {31'b0, Sm_Tick}, {31'b0, mon_e.tick});
          chk("ev_BtnL_Pulse", {31'b0, BtnL_Pulse}, {31'b0, mon_e.lp});
          chk("ev_BtnR_Pulse", {31'b0, BtnR_Pulse}, {31'b0, mon_e.rp});
          chk("ev_L_Rbar", {31'b0, L_Rbar}, {31'b0, mon_e.lr});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase A: reset, tick cadence, bounce, long press, dual press, press on tick
    repeat (3) @(negedge Clk);
    chk_reset_state("rstA");
    push( 8, 1, 0, 0, 0);
    push(16, 1, 0, 0, 0);
    push(19, 0, 1, 0, 0);
    push(24, 1, 0, 0, 0);
    push(32, 1, 0, 0, 1);
    push(40, 1, 0, 0, 1);
    push(47, 0, 1, 1, 1);
    push(48, 1, 0, 0, 1);
    push(56, 1, 0, 0, 1);
    push(64, 1, 0, 0, 1);
    push(72, 1, 0, 1, 1);
    push(80, 1, 0, 0, 1);
    push(88, 1, 0, 0, 0);
    reset = 1'b0;
    wu(2);  BtnL = 1'b1;
    wu(4);  BtnL = 1'b0;
    wu(5);  BtnL = 1'b1;
    wu(7);  BtnL = 1'b0;
    wu(12); BtnL = 1'b1;
    wu(32); BtnL = 1'b0;
    wu(40); BtnL = 1'b1; BtnR = 1'b1;
    wu(60); BtnL = 1'b0; BtnR = 1'b0;
    wu(65); BtnR = 1'b1;
    wu(75); BtnR = 1'b0;
    wu(90); BtnL = 1'b1;
    wu(95); reset = 1'b1;

    // Phase B: reset hit mid-debounce; the still-held press is debounced afresh
    repeat (2) @(negedge Clk);
    chk("sb_drained_A", sb.size(), 0);
    chk_reset_state("rstB");
    push( 7, 0, 1, 0, 0);
    push( 8, 1, 0, 0, 0);
    push(16, 1, 0, 0, 1);
    reset = 1'b0;
    wu(10); BtnL = 1'b0;
    wu(20);
    chk("L_Rbar_after_B", {31'b0, L_Rbar}, 1);

`ifdef DETOUR_HOLD_EN
    // Phase C: tick frozen by Hold while debounce keeps running
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("sb_drained_B", sb.size(), 0);
    chk_reset_state("rstC");
    push(12, 0, 1, 0, 0);
    push(28, 1, 0, 0, 0);
    push(36, 1, 0, 0, 1);
    reset = 1'b0;
    wu(3);  Hold = 1'b1;
    wu(5);  BtnL = 1'b1;
    wu(15); BtnL = 1'b0;
    wu(23); Hold = 1'b0;
    wu(40);
`endif

    chk("sb_drained_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
